led_pattern_engine: RTL
=======================

// Module: led_pattern_engine
// PURPOSE
//  Parametrised LED sequencer; successor to the fixed 4-LED, 0.5 s one-hot chaser.
//  Drives LED_NUM outputs with a runtime-selectable pattern mode and a runtime step period.
//  Emits step and wrap pulses for other PL logic.
//  Sits after the PLL clock output, fed by the PLL domain clock; LED pins are on the PL side.
// PARAMETERS
//  LED_NUM     4            number of LED outputs; must be >= 2 (elaboration-time check)
//  DIV_W       32           width of the period input and the prescaler counter
//  CLOCK_FREQ  100_000_000  documentation only; period = CLOCK_FREQ/2 gives a 0.5 s step
// PORTS
//  clk         in   1        PLL output clock; every register is on posedge clk
//  rst         in   1        synchronous, active-high reset
//  en          in   1        1 = run; 0 = freeze the prescaler and the pattern
//  mode        in   3        0 SHIFT_L, 1 SHIFT_R, 2 PINGPONG, 3 COUNT, 4 BLINK, 5-7 OFF
//  period      in   DIV_W    clocks per step; 0 is treated as 1
//  restart     in   1        1-cycle pulse; returns the pattern to the mode's start state
//  led         out  LED_NUM  registered LED drive; 1 = LED on
//  step_pulse  out  1        1-cycle pulse on each step, aligned with the new led value
//  wrap_pulse  out  1        1-cycle pulse when the sequence completes a cycle
// BEHAVIOUR
//  Reset (sync)
//   - cnt=0, pos=0, dir=up, mode_q=0.
//   - led={{LED_NUM-1{0}},1}.
//   - step_pulse=0, wrap_pulse=0.
//  Prescaler
//   - tick = en && (cnt >= period_eff-1); period_eff = max(period,1).
//   - On tick: cnt<=0. Otherwise, if en: cnt<=cnt+1. If en=0: cnt holds.
//   - The >= compare means lowering period mid-count gives a tick on the next enabled cycle.
//  Step (on tick): pattern advances; led takes the new value on the same edge.
//   - step_pulse<=1 on that edge, 0 on every other edge.
//   - SHIFT_L: one-hot bit pos moves LSB->MSB. Wrap at pos LED_NUM-1 -> 0.
//   - SHIFT_R: one-hot bit pos moves MSB->LSB. Wrap at pos 0 -> LED_NUM-1.
//   - PINGPONG: one-hot bounce. Reverses dir on reaching an end; the end LED shows exactly once.
//     Wrap fires when the bounce reaches pos 0 (one full round trip).
//   - COUNT: led is a binary counter, +1 per step. Wrap at all-ones -> 0.
//   - BLINK: all LEDs toggle together. Wrap on each on->off transition.
//   - OFF (mode 5-7): led=0, no steps. step_pulse and wrap_pulse stay 0.
//  wrap_pulse: registered, same edge as the step_pulse that completes the wrap.
//  Mode change (mode != mode_q)
//   - Next edge: mode_q<=mode, cnt<=0, dir=up, pattern<=start state; no step_pulse.
//   - Start states: SHIFT_L/PINGPONG 0..01; SHIFT_R 10..0; COUNT 0; BLINK all-on.
//  restart: same effect as a mode change.
//   - Priority: rst > restart/mode change > tick.
//  en=0: led, cnt, pos and dir hold; both pulses are 0.
//  rst while running: state aborts; the next cycle shows reset values.
// CONFIGURATION
//  LED_PWM_DIM_EN defined
//   - Adds input port duty[7:0] and an 8-bit free-running pwm_cnt (reset 0).
//   - led = pattern & {LED_NUM{pwm_cnt < duty}}, registered, i.e. duty/256 brightness.
//   - duty=0: LEDs always off. Pattern, step_pulse and wrap_pulse are unaffected.
//  LED_PWM_DIM_EN undefined
//   - No duty port, no pwm logic.
//   - led = pattern at full drive.
// STRUCTURE
//  Package led_pkg
//   - typedef enum logic [2:0] led_mode_e {SHIFT_L, SHIFT_R, PINGPONG, COUNT, BLINK, OFF=5}.
//   - localparam PWM_W = 8.
//  Sub-module led_tick_gen: period prescaler.
//   - In: clk, rst, en, period, clr. Out: tick.
//   - Reusable by other timed blocks.
//  Top holds the pattern state machine, the pulse registers and the optional PWM stage.
// TESTING
//  1. Defaults, mode=0, period=4, en=1 after rst
//     -> led 0001,0010,0100,1000,0001, each 4 clk apart.
//     -> wrap_pulse once, at the 1000->0001 step.
//  2. mode=2, period=1 -> led 0001,0010,0100,1000,0100,0010,0001.
//     -> wrap_pulse only at the return to 0001.
//  3. mode=3, period=2, LED_NUM=4 -> led counts 0..15 then 0.
//     -> wrap_pulse at 15->0; step_pulse every 2nd clk.
//  4. period 100 -> 3 when cnt=50 -> tick on the next clk.
//     -> en=0 for 10 clk freezes led and cnt; no pulses.
//  5. Mode switch 0->4 mid-count -> led=1111 on the next clk, cnt=0.
//     -> restart pulse in mode 1 -> led=1000.
//     -> rst asserted during a step -> led=0001, pulses 0.
//  6. With LED_PWM_DIM_EN, duty=64, led pattern 0001
//     -> led[0] high 64 of every 256 clk.
//     -> duty=0 keeps led=0 while step_pulse still toggles.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED pattern engine
//
// Purpose: pattern mode encoding, PWM width, direction encoding and a
//          helper that classifies the OFF modes (5-7).
// Ports:   none (package)

package led_pkg;

  typedef enum logic [2:0] {
    SHIFT_L  = 3'd0,
    SHIFT_R  = 3'd1,
    PINGPONG = 3'd2,
    COUNT    = 3'd3,
    BLINK    = 3'd4,
    OFF      = 3'd5
  } led_mode_e;

  localparam int PWM_W = 8;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Encodings 5, 6 and 7 all mean OFF.
  function automatic logic mode_is_off(input logic [2:0] m);
    return m >= 3'(OFF);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - enable-gated period prescaler producing a step tick
//
// Purpose: counts enabled clocks and raises tick on the last clock of each
//          period. A period of 0 behaves as 1 (tick on every enabled clock).
// Ports:
//   clk    in   1      clock, all registers on posedge
//   rst    in   1      synchronous active-high reset
//   en     in   1      count enable; counter holds while low
//   period in   DIV_W  clocks per tick
//   clr    in   1      synchronous counter clear, wins over tick
//   tick   out  1      combinational tick for the current cycle

module led_tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  input  logic             clr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period_m1;

  assign period_m1 = (period == '0) ? '0 : period - DIV_W'(1);

  // >= rather than == so that shrinking period below the current count
  // fires on the next enabled cycle instead of waiting for a counter wrap.
  assign tick = en && (cnt >= period_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - parametrised LED sequencer with step and wrap pulses
//
// Purpose: drives LED_NUM LEDs with a runtime-selected pattern advancing once
//          per programmable period. Optional feature macro LED_PWM_DIM_EN adds
//          a duty input that dims the LEDs with an 8-bit PWM.
// Ports:
//   clk         in   1        PLL output clock
//   rst         in   1        synchronous active-high reset
//   en          in   1        run enable; 0 freezes prescaler and pattern
//   mode        in   3        0 SHIFT_L 1 SHIFT_R 2 PINGPONG 3 COUNT 4 BLINK 5-7 OFF
//   period      in   DIV_W    clocks per step (0 acts as 1)
//   restart     in   1        pulse: return pattern to the mode's start state
//   duty        in   8        PWM duty, only with LED_PWM_DIM_EN
//   led         out  LED_NUM  registered LED drive, 1 = on
//   step_pulse  out  1        pulse on each step, aligned with new led value
//   wrap_pulse  out  1        pulse when the pattern completes a cycle

module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_NUM    = 4,
  parameter int DIV_W      = 32,
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [DIV_W-1:0]   period,
  input  logic               restart,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_W-1:0]   duty,
`endif
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse,
  output logic               wrap_pulse
);

  generate
    if (LED_NUM < 2 || CLOCK_FREQ < 1) begin : g_bad_param
      $error("led_pattern_engine: LED_NUM must be >= 2 and CLOCK_FREQ positive");
    end
  endgenerate

  localparam int POS_W = $clog2(LED_NUM);
  localparam logic [POS_W-1:0]   POS_MAX = POS_W'(LED_NUM - 1);
  localparam logic [LED_NUM-1:0] LED_ONE = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] LED_MSB = {1'b1, {(LED_NUM-1){1'b0}}};

  logic [2:0]         mode_q;
  logic [LED_NUM-1:0] pat, pat_nxt;
  logic [POS_W-1:0]   pos, pos_nxt;
  logic               dir, dir_nxt;
  logic               step_nxt, wrap_nxt;
  logic               chg;
  logic               tick;

  // A mode change behaves exactly like restart, so both feed one clear.
  assign chg = restart || (mode != mode_q);

  led_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .clr    (chg),
    .tick   (tick)
  );

  always_comb begin
    pat_nxt  = pat;
    pos_nxt  = pos;
    dir_nxt  = dir;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (chg) begin
      dir_nxt = DIR_UP;
      pos_nxt = '0;
      case (mode)
        SHIFT_L, PINGPONG: pat_nxt = LED_ONE;
        SHIFT_R: begin
          pos_nxt = POS_MAX;
          pat_nxt = LED_MSB;
        end
        COUNT:   pat_nxt = '0;
        BLINK:   pat_nxt = '1;
        default: pat_nxt = '0;
      endcase
    end else if (tick && !mode_is_off(mode_q)) begin
      step_nxt = 1'b1;
      case (mode_q)
        SHIFT_L: begin
          wrap_nxt = (pos == POS_MAX);
          pos_nxt  = wrap_nxt ? '0 : pos + POS_W'(1);
          pat_nxt  = LED_ONE << pos_nxt;
        end
        SHIFT_R: begin
          wrap_nxt = (pos == '0);
          pos_nxt  = wrap_nxt ? POS_MAX : pos - POS_W'(1);
          pat_nxt  = LED_ONE << pos_nxt;
        end
        PINGPONG: begin
          // Turning around at an end moves straight to the neighbour, so each
          // end LED is shown once per sweep.
          if (dir == DIR_UP) begin
            if (pos == POS_MAX) begin
              pos_nxt = pos - POS_W'(1);
              dir_nxt = DIR_DN;
            end else begin
              pos_nxt = pos + POS_W'(1);
            end
          end else begin
            if (pos == '0) begin
              pos_nxt = pos + POS_W'(1);
              dir_nxt = DIR_UP;
            end else begin
              pos_nxt = pos - POS_W'(1);
            end
          end
          wrap_nxt = (pos_nxt == '0);
          pat_nxt  = LED_ONE << pos_nxt;
        end
        COUNT: begin
          wrap_nxt = &pat;
          pat_nxt  = pat + LED_NUM'(1);
        end
        BLINK: begin
          // All bits move together; all-ones means this step turns them off.
          wrap_nxt = &pat;
          pat_nxt  = ~pat;
        end
        default: begin
          step_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 3'(SHIFT_L);
      pat        <= LED_ONE;
      pos        <= '0;
      dir        <= DIR_UP;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      mode_q     <= mode;
      pat        <= pat_nxt;
      pos        <= pos_nxt;
      dir        <= dir_nxt;
      step_pulse <= step_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0]   pwm_cnt;
  logic [LED_NUM-1:0] led_q;

  // Masking pat_nxt keeps the dimmed led aligned with step_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      led_q   <= LED_ONE;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led_q   <= pat_nxt & {LED_NUM{pwm_cnt < duty}};
    end
  end

  assign led = led_q;
`else
  assign led = pat;
`endif

endmodule
